wave_sequencer: RTL

//   Sequencer that drives the waveform controller. Holds a DDS phase accumulator
//   and produces the 9-bit phase address plus the enable/wave_word/pwm_word

---
 rtl/wave_pkg.sv | 16 +
 rtl/phase_accum.sv | 30 +++
 rtl/wave_sequencer.sv | 106 ++++++++++
 3 files changed

// File: rtl/wave_pkg.sv
// wave_pkg: shared wave-select codes, sequencer state encoding and default widths
package wave_pkg;
    localparam int ACC_W_DEF  = 24;
    localparam int ADDR_W_DEF = 9;
    typedef enum logic [1:0] {
        WAVE_SINE = 2'b00,
        WAVE_TRI  = 2'b01,
        WAVE_SQR  = 2'b10,
        WAVE_PWM  = 2'b11
    } wave_e;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10
    } state_e;
endpackage

// File: rtl/phase_accum.sv
// phase_accum: DDS phase accumulator with carry-out wrap detect
//   clk, rst  clock, async active-high reset
//   en        advance acc by freq this cycle
//   clr       synchronous clear (wins over en)
//   freq      phase increment
//   address   top ADDR_W bits of the accumulator
//   wrap      combinational carry out of acc+freq while enabled
module phase_accum #(
    parameter int ACC_W  = 24,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [ACC_W-1:0]  freq,
    output logic [ADDR_W-1:0] address,
    output logic              wrap
);
    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;
    assign sum     = {1'b0, acc} + {1'b0, freq};
    assign wrap    = en && sum[ACC_W];
    assign address = acc[ACC_W-1 -: ADDR_W];
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      acc <= '0;
        else if (clr) acc <= '0;
        else if (en)  acc <= sum[ACC_W-1:0];
    end
endmodule

// File: rtl/wave_sequencer.sv
// wave_sequencer: DDS sequencer with period-boundary config apply and stop
//   clk, rst     clock, async active-high reset
//   start, stop  1-cycle control pulses
//   cfg_valid/cfg_ready/cfg_freq/cfg_wave/cfg_pwm  config handshake into shadow
//   enable, busy high while running or draining
//   wave_word, pwm_word  active wave select and PWM threshold
//   address      phase address, period_tick  pulse aligned with a period's first address
module wave_sequencer
    import wave_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ACC_W-1:0]  cfg_freq,
    input  logic [1:0]        cfg_wave,
    input  logic [6:0]        cfg_pwm,
    output logic              enable,
    output logic [1:0]        wave_word,
    output logic [6:0]        pwm_word,
    output logic [ADDR_W-1:0] address,
    output logic              period_tick,
    output logic              busy
);
    state_e           state, state_nx;
    logic [ACC_W-1:0] freq, sh_freq;
    logic [1:0]       sh_wave;
    logic [6:0]       sh_pwm;
    logic             sh_full, wrap, run, clr, take, apply, drain_done;

    assign run        = state != ST_IDLE;
    // a zero step never wraps, so draining with freq==0 finishes at once
    assign drain_done = state == ST_DRAIN && (wrap || freq == '0);
    assign clr        = state == ST_IDLE || drain_done;
    assign take       = cfg_valid && !sh_full;
    // shadow only lands on a period boundary while generating
    assign apply      = sh_full && (state == ST_IDLE || wrap);
    assign cfg_ready  = !sh_full;

    phase_accum #(.ACC_W(ACC_W), .ADDR_W(ADDR_W)) u_accum (
        .clk     (clk),
        .rst     (rst),
        .en      (run),
        .clr     (clr),
        .freq    (freq),
        .address (address),
        .wrap    (wrap)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  state_nx = (start && !stop) ? ST_RUN : ST_IDLE;
            ST_RUN:   state_nx = stop ? ST_DRAIN : ST_RUN;
            ST_DRAIN: state_nx = drain_done ? ST_IDLE : ST_DRAIN;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            enable      <= 1'b0;
            busy        <= 1'b0;
            period_tick <= 1'b0;
        end else begin
            state       <= state_nx;
            enable      <= state_nx != ST_IDLE;
            busy        <= state_nx != ST_IDLE;
            period_tick <= wrap;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_full <= 1'b0;
            sh_freq <= '0;
            sh_wave <= '0;
            sh_pwm  <= '0;
        end else if (take) begin
            sh_full <= 1'b1;
            sh_freq <= cfg_freq;
            sh_wave <= cfg_wave;
            sh_pwm  <= cfg_pwm;
        end else if (apply) begin
            sh_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            freq      <= '0;
            wave_word <= '0;
            pwm_word  <= '0;
        end else if (apply) begin
            freq      <= sh_freq;
            wave_word <= sh_wave;
            pwm_word  <= sh_pwm;
        end
    end
endmodule
